tx_trn_arbiter: RTL and testbench

- Owns the PCIe TRN transmit interface for the DMA engine.
- Turns each read_chunk request from the huge-page fetch logic into one 64-bit Memory Read TLP of 512 bytes.
- Shares the TX link with a second requester, the host-write TLP engine, through a req/gnt handshake with TLP-boundary arbitration.
- Limits outstanding read requests and assigns a rolling tag to each read.

---
 rtl/tx_trn_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_tx_trn_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_trn_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tx_trn_arbiter
// Purpose  : Owns the PCIe TRN transmit interface. Turns each read_chunk
//            request into one 64-bit Memory Read TLP (RD_LEN_DW DWs) and
//            shares the link with the host-write TLP engine via a req/gnt
//            handshake arbitrated on TLP boundaries. Limits outstanding reads
//            and stamps each MRd with a rolling tag.
// Ports    : trn_clk, reset_n (async, active low)
//            cfg_completer_id          - requester ID for MRd headers
//            read_chunk / _ack         - read request level / 1-cycle ack
//            huge_page_addr_read_from  - MRd byte address
//            cpl_done                  - one chunk's completions received
//            wr_req / wr_gnt / wr_*    - write engine handshake and TLP beats
//            trn_*                     - TRN TX interface to the core
// Options  : `define TX_RD_STRICT_PRIO_EN gives reads strict priority over
//            writes in IDLE; otherwise requesters alternate (round-robin).
// Revision : 1.0 - initial release
// ============================================================================
module tx_trn_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TAG_WIDTH       = 5,
    parameter int RD_LEN_DW       = 128
) (
    input  logic        trn_clk,
    input  logic        reset_n,
    input  logic [15:0] cfg_completer_id,
    input  logic        read_chunk,
    input  logic [63:0] huge_page_addr_read_from,
    output logic        read_chunk_ack,
    input  logic        cpl_done,
    input  logic        wr_req,
    output logic        wr_gnt,
    input  logic [63:0] wr_td,
    input  logic [7:0]  wr_trem_n,
    input  logic        wr_tsof_n,
    input  logic        wr_teof_n,
    input  logic        wr_tsrc_rdy_n,
    output logic [63:0] trn_td,
    output logic [7:0]  trn_trem_n,
    output logic        trn_tsof_n,
    output logic        trn_teof_n,
    output logic        trn_tsrc_rdy_n,
    input  logic        trn_tdst_rdy_n
);

    // One-hot state encoding
    localparam logic [3:0] S_IDLE    = 4'b0001;
    localparam logic [3:0] S_RD_HDR0 = 4'b0010;
    localparam logic [3:0] S_RD_HDR1 = 4'b0100;
    localparam logic [3:0] S_WR      = 4'b1000;

    localparam logic LS_WR = 1'b0;
    localparam logic LS_RD = 1'b1;

    localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);
    localparam logic [9:0]  LEN_DW  = 10'(RD_LEN_DW);
    // MRd DW0: fmt=01 (4DW header, no data), type=00000, TC/attr/TD/EP zero.
    localparam logic [31:0] MRD_DW0 = {1'b0, 2'b01, 5'b00000, 1'b0, 3'b000,
                                       4'b0000, 1'b0, 1'b0, 2'b00, 2'b00, LEN_DW};
    // Address DW1/DW2 carry addr[63:2]; the two low bits are reserved zero.
    localparam logic [63:0] ADDR_DW_MASK = ~64'h3;

    logic [3:0]           state;
    logic [3:0]           next_state;
    logic [63:0]          rd_addr;
    logic [TAG_WIDTH-1:0] tag;
    logic [3:0]           outstanding;
    logic                 last_served;
    logic                 ack_pulse;
    logic                 gnt;
    logic [63:0]          hdr_td;
    logic                 hdr_sof_n;
    logic                 hdr_eof_n;
    logic                 hdr_src_rdy_n;

    logic                 beat_acc;
    logic                 rd_elig;
    logic                 rd_win;
    logic                 wr_win;
    logic                 rd_done;
    logic                 wr_done;

    assign beat_acc = !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
    // The ack term blocks re-issue in the cycle where the requester has not
    // yet seen the ack and is still holding read_chunk for the old chunk.
    assign rd_elig  = read_chunk && (outstanding < MAX_OUT) && !read_chunk_ack;
    assign rd_done  = (state == S_RD_HDR1) && beat_acc;
    assign wr_done  = (state == S_WR) && beat_acc && !wr_teof_n;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic, including IDLE arbitration
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        rd_win     = 1'b0;
        wr_win     = 1'b0;
        if (rd_elig && wr_req) begin
`ifdef TX_RD_STRICT_PRIO_EN
            rd_win = 1'b1;
`else
            rd_win = (last_served == LS_WR);
`endif
            wr_win = !rd_win;
        end else begin
            rd_win = rd_elig;
            wr_win = wr_req;
        end

        case (state)
            S_IDLE: begin
                if (rd_win) begin
                    next_state = S_RD_HDR0;
                end else if (wr_win) begin
                    next_state = S_WR;
                end
            end
            S_RD_HDR0: begin
                if (beat_acc) begin
                    next_state = S_RD_HDR1;
                end
            end
            S_RD_HDR1: begin
                if (beat_acc) begin
                    next_state = S_IDLE;
                end
            end
            S_WR: begin
                if (wr_done) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registered MRd beats, handshake, tag and outstanding bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr       <= '0;
            hdr_td        <= '0;
            hdr_sof_n     <= 1'b1;
            hdr_eof_n     <= 1'b1;
            hdr_src_rdy_n <= 1'b1;
            ack_pulse     <= 1'b0;
            gnt           <= 1'b0;
            tag           <= '0;
            outstanding   <= '0;
            last_served   <= LS_WR;
        end else begin
            ack_pulse <= rd_done;

            if ((state == S_IDLE) && (next_state == S_RD_HDR0)) begin
                rd_addr       <= huge_page_addr_read_from;
                hdr_td        <= {MRD_DW0, cfg_completer_id, 8'(tag), 4'hF, 4'hF};
                hdr_sof_n     <= 1'b0;
                hdr_eof_n     <= 1'b1;
                hdr_src_rdy_n <= 1'b0;
            end else if ((state == S_RD_HDR0) && beat_acc) begin
                hdr_td        <= rd_addr & ADDR_DW_MASK;
                hdr_sof_n     <= 1'b1;
                hdr_eof_n     <= 1'b0;
            end else if (rd_done) begin
                hdr_td        <= '0;
                hdr_sof_n     <= 1'b1;
                hdr_eof_n     <= 1'b1;
                hdr_src_rdy_n <= 1'b1;
            end

            if ((state == S_IDLE) && (next_state == S_WR)) begin
                gnt <= 1'b1;
            end else if (wr_done) begin
                gnt <= 1'b0;
            end

            if (rd_done) begin
                tag         <= tag + TAG_WIDTH'(1);
                last_served <= LS_RD;
            end else if (wr_done) begin
                last_served <= LS_WR;
            end

            // Simultaneous issue and completion cancel; a stray completion
            // with nothing outstanding is dropped rather than wrapping.
            case ({rd_done, cpl_done})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   if (outstanding != 4'd0) outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic: write TLPs pass straight through while granted
    // ------------------------------------------------------------------
    always_comb begin
        trn_td         = hdr_td;
        trn_trem_n     = 8'h00;
        trn_tsof_n     = hdr_sof_n;
        trn_teof_n     = hdr_eof_n;
        trn_tsrc_rdy_n = hdr_src_rdy_n;
        if (state == S_WR) begin
            trn_td         = wr_td;
            trn_trem_n     = wr_trem_n;
            trn_tsof_n     = wr_tsof_n;
            trn_teof_n     = wr_teof_n;
            trn_tsrc_rdy_n = wr_tsrc_rdy_n;
        end
        read_chunk_ack = ack_pulse;
        wr_gnt         = gnt;
    end

endmodule
`default_nettype wire

// File: tb/tb_tx_trn_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tx_trn_arbiter
// Purpose  : Directed self-checking bench for tx_trn_arbiter. Expected TLP
//            beats are queued as stimulus is applied and compared as the DUT
//            hands beats to the core. Build with +define+TX_RD_STRICT_PRIO_EN
//            to check the strict read-priority variant.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tx_trn_arbiter;

    logic        trn_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] cfg_completer_id = 16'h0100;
    logic        read_chunk = 1'b0;
    logic [63:0] huge_page_addr_read_from = '0;
    logic        read_chunk_ack;
    logic        cpl_done = 1'b0;
    logic        wr_req = 1'b0;
    logic        wr_gnt;
    logic [63:0] wr_td = '0;
    logic [7:0]  wr_trem_n = '0;
    logic        wr_tsof_n = 1'b1;
    logic        wr_teof_n = 1'b1;
    logic        wr_tsrc_rdy_n = 1'b1;
    logic [63:0] trn_td;
    logic [7:0]  trn_trem_n;
    logic        trn_tsof_n;
    logic        trn_teof_n;
    logic        trn_tsrc_rdy_n;
    logic        trn_tdst_rdy_n = 1'b0;

    always #5 trn_clk = ~trn_clk;

    tx_trn_arbiter dut (
        .trn_clk                  (trn_clk),
        .reset_n                  (reset_n),
        .cfg_completer_id         (cfg_completer_id),
        .read_chunk               (read_chunk),
        .huge_page_addr_read_from (huge_page_addr_read_from),
        .read_chunk_ack           (read_chunk_ack),
        .cpl_done                 (cpl_done),
        .wr_req                   (wr_req),
        .wr_gnt                   (wr_gnt),
        .wr_td                    (wr_td),
        .wr_trem_n                (wr_trem_n),
        .wr_tsof_n                (wr_tsof_n),
        .wr_teof_n                (wr_teof_n),
        .wr_tsrc_rdy_n            (wr_tsrc_rdy_n),
        .trn_td                   (trn_td),
        .trn_trem_n               (trn_trem_n),
        .trn_tsof_n               (trn_tsof_n),
        .trn_teof_n               (trn_teof_n),
        .trn_tsrc_rdy_n           (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n           (trn_tdst_rdy_n)
    );

    typedef struct packed {
        logic [63:0] td;
        logic [7:0]  trem_n;
        logic        sof_n;
        logic        eof_n;
    } beat_t;

    beat_t      exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_tag = 8'd0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare any beat the core accepts just before the edge,
    // then return 1ns after the edge for the next directed step.
    task automatic tick();
        beat_t got;
        beat_t e;
        @(negedge trn_clk);
        #4;
        if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
            got = {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n};
            if (exp_q.size() == 0) begin
                chk("unexpected_beat_queue_size", 80'(exp_q.size()), 80'd1);
            end else begin
                e = exp_q.pop_front();
                chk("beat", 80'(got), 80'(e));
            end
        end
        @(posedge trn_clk);
        #1;
    endtask

    task automatic push_rd(input logic [63:0] a);
        beat_t e;
        e.td     = {32'h2000_0080, cfg_completer_id, exp_tag, 8'hFF};
        e.trem_n = 8'h00;
        e.sof_n  = 1'b0;
        e.eof_n  = 1'b1;
        exp_q.push_back(e);
        e.td     = {a[63:2], 2'b00};
        e.sof_n  = 1'b1;
        e.eof_n  = 1'b0;
        exp_q.push_back(e);
        exp_tag = (exp_tag == 8'd31) ? 8'd0 : exp_tag + 8'd1;
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int n;
        tick();
        n = 1;
        while (read_chunk_ack !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 80'(read_chunk_ack), 80'd1);
    endtask

    task automatic chk_idle(input string tag);
        chk(tag, 80'({trn_tsrc_rdy_n, trn_tsof_n, trn_teof_n, trn_trem_n, trn_td}),
            80'({1'b1, 1'b1, 1'b1, 8'h00, 64'h0}));
    endtask

    task automatic wr_one_beat(input logic [63:0] d);
        beat_t e;
        wr_td = d; wr_trem_n = 8'h00; wr_tsof_n = 1'b0; wr_teof_n = 1'b0; wr_tsrc_rdy_n = 1'b0;
        e = {d, 8'h00, 1'b0, 1'b0};
        exp_q.push_back(e);
        tick();
        wr_req = 1'b0; wr_tsrc_rdy_n = 1'b1; wr_tsof_n = 1'b1; wr_teof_n = 1'b1;
        chk("wr_gnt_drop", 80'(wr_gnt), 80'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        read_chunk = 1'b0; wr_req = 1'b0; cpl_done = 1'b0; trn_tdst_rdy_n = 1'b0;
        wr_tsrc_rdy_n = 1'b1; wr_tsof_n = 1'b1; wr_teof_n = 1'b1;
        exp_q.delete();
        exp_tag = 8'd0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int         b;
        int         cyc;
        logic       acc;
        beat_t      e;
        logic [63:0] a;

        // ---- 1: single MRd, latency, tag increment ----
        do_reset();
        chk("rst_ack", 80'(read_chunk_ack), 80'd0);
        chk("rst_gnt", 80'(wr_gnt), 80'd0);
        chk_idle("rst_tx_idle");
        huge_page_addr_read_from = 64'h0000_0001_2345_6780;
        read_chunk = 1'b1;
        push_rd(huge_page_addr_read_from);
        tick();
        chk("t1_sof_lat", 80'({trn_tsof_n, trn_tsrc_rdy_n}), 80'd0);
        chk("t1_hdr0", 80'(trn_td), 80'(64'h2000_0080_0100_00FF));
        tick();
        chk("t1_eof_lat", 80'({trn_teof_n, trn_tsof_n}), 80'(2'b01));
        chk("t1_hdr1", 80'(trn_td), 80'(64'h0000_0001_2345_6780));
        chk("t1_no_early_ack", 80'(read_chunk_ack), 80'd0);
        tick();
        chk("t1_ack_lat", 80'(read_chunk_ack), 80'd1);
        read_chunk = 1'b0;
        chk_idle("t1_idle_after");
        tick();
        chk("t1_ack_pulse", 80'(read_chunk_ack), 80'd0);
        huge_page_addr_read_from = 64'h0000_0000_DEAD_BE00;
        read_chunk = 1'b1;
        push_rd(huge_page_addr_read_from);
        tick();
        chk("t1_tag1", 80'(trn_td[15:8]), 80'd1);
        wait_ack("t1_ack2", 10);
        read_chunk = 1'b0;
        tick();
        chk("t1_drain", 80'(exp_q.size()), 80'd0);

        // ---- 2: outstanding limit and cpl_done handling ----
        do_reset();
        cpl_done = 1'b1;           // counter at 0: must stay 0
        tick();
        cpl_done = 1'b0;
        a = 64'h0000_0003_0000_0000;
        huge_page_addr_read_from = a;
        read_chunk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_rd(a);
            wait_ack("t2_ack", 10);
            a = a + 64'd512;
            huge_page_addr_read_from = a;
        end
        repeat (8) tick();
        chk("t2_blocked", 80'(trn_tsrc_rdy_n), 80'd1);
        cpl_done = 1'b1;
        push_rd(a);
        tick();
        cpl_done = 1'b0;
        tick();
        chk("t2_5th_sof", 80'(trn_tsof_n), 80'd0);
        wait_ack("t2_ack5", 10);
        read_chunk = 1'b0;
        tick();
        chk("t2_drain", 80'(exp_q.size()), 80'd0);

        // ---- 3: arbitration ----
        do_reset();
        wr_req = 1'b1;
        tick();
        chk("t3_wr_alone", 80'(wr_gnt), 80'd1);
        wr_one_beat(64'h1111_0000_0000_0001);
        repeat (2) tick();         // last served: write
        huge_page_addr_read_from = 64'h0000_0004_0000_0040;
        read_chunk = 1'b1;
        wr_req = 1'b1;
        push_rd(huge_page_addr_read_from);
        tick();
        chk("t3_tie1_rd", 80'({wr_gnt, trn_tsof_n}), 80'(2'b00));
        wait_ack("t3_ack1", 10);
        read_chunk = 1'b0;
        wr_req = 1'b0;
        repeat (2) tick();         // last served: read
        read_chunk = 1'b1;
        wr_req = 1'b1;
`ifdef TX_RD_STRICT_PRIO_EN
        push_rd(huge_page_addr_read_from);
        tick();
        chk("t3_tie2_rd", 80'({wr_gnt, trn_tsof_n}), 80'(2'b00));
        wait_ack("t3_ack2", 10);
        read_chunk = 1'b0;
        tick();
        chk("t3_wr_after", 80'(wr_gnt), 80'd1);
        wr_one_beat(64'h2222_0000_0000_0002);
`else
        tick();
        chk("t3_tie2_wr", 80'({wr_gnt, trn_tsof_n}), 80'(2'b11));
        wr_one_beat(64'h2222_0000_0000_0002);
        push_rd(huge_page_addr_read_from);
        tick();
        chk("t3_rd_after", 80'(trn_tsof_n), 80'd0);
        wait_ack("t3_ack2", 10);
        read_chunk = 1'b0;
`endif
        tick();
        chk("t3_drain", 80'(exp_q.size()), 80'd0);

        // ---- 4: destination stall during header beat ----
        do_reset();
        trn_tdst_rdy_n = 1'b1;
        huge_page_addr_read_from = 64'h0000_0005_0000_0800;
        read_chunk = 1'b1;
        push_rd(huge_page_addr_read_from);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold", 80'({trn_td, trn_tsof_n, trn_tsrc_rdy_n, read_chunk_ack}),
                80'({64'h2000_0080_0100_00FF, 1'b0, 1'b0, 1'b0}));
            tick();
        end
        trn_tdst_rdy_n = 1'b0;
        wait_ack("t4_ack", 10);
        read_chunk = 1'b0;
        tick();
        chk("t4_drain", 80'(exp_q.size()), 80'd0);

        // ---- 5: 3-beat write with toggling destination ready ----
        do_reset();
        huge_page_addr_read_from = 64'h0000_0006_0000_1000;
        wr_req = 1'b1;
        tick();
        chk("t5_gnt", 80'(wr_gnt), 80'd1);
        read_chunk = 1'b1;         // pending read waits for the write
        b = 0;
        cyc = 0;
        while (b < 3 && cyc < 20) begin
            wr_td         = 64'hC0DE_0000_0000_0000 + 64'(b * 3 + 1);
            wr_trem_n     = (b == 2) ? 8'h0F : 8'h00;
            wr_tsof_n     = (b != 0);
            wr_teof_n     = (b != 2);
            wr_tsrc_rdy_n = 1'b0;
            trn_tdst_rdy_n = (cyc % 2 == 0);
            #1;
            chk("t5_mirror", 80'({trn_td, trn_trem_n, trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}),
                80'({wr_td, wr_trem_n, wr_tsof_n, wr_teof_n, wr_tsrc_rdy_n}));
            acc = !trn_tdst_rdy_n;
            if (acc) begin
                e = {wr_td, wr_trem_n, wr_tsof_n, wr_teof_n};
                exp_q.push_back(e);
            end
            tick();
            cyc++;
            if (acc) b++;
        end
        chk("t5_beats_done", 80'(b), 80'd3);
        wr_req = 1'b0; wr_tsrc_rdy_n = 1'b1; wr_tsof_n = 1'b1; wr_teof_n = 1'b1;
        trn_tdst_rdy_n = 1'b0;
        chk("t5_gnt_drop", 80'(wr_gnt), 80'd0);
        chk_idle("t5_idle_gap");
        push_rd(huge_page_addr_read_from);
        tick();
        chk("t5_rd_start", 80'(trn_tsof_n), 80'd0);
        wait_ack("t5_ack", 10);
        read_chunk = 1'b0;
        tick();
        chk("t5_drain", 80'(exp_q.size()), 80'd0);

        // ---- 6: reset during second header beat ----
        do_reset();
        huge_page_addr_read_from = 64'h0000_0007_0000_2000;
        read_chunk = 1'b1;
        push_rd(huge_page_addr_read_from);
        wait_ack("t6_ack_first", 10);
        huge_page_addr_read_from = 64'h0000_0007_0000_4000;
        push_rd(huge_page_addr_read_from);
        tick();
        tick();
        tick();
        chk("t6_in_hdr1", 80'({trn_teof_n, trn_tsrc_rdy_n}), 80'd0);
        reset_n = 1'b0;
        #1;
        chk_idle("t6_abort");
        chk("t6_abort_ack", 80'({read_chunk_ack, wr_gnt}), 80'd0);
        exp_q.delete();
        exp_tag = 8'd0;
        tick();
        reset_n = 1'b1;
        push_rd(huge_page_addr_read_from);
        tick();
        chk("t6_reissue_sof", 80'(trn_tsof_n), 80'd0);
        chk("t6_tag0", 80'(trn_td[15:8]), 80'd0);
        wait_ack("t6_ack", 10);
        read_chunk = 1'b0;
        tick();
        chk("t6_drain", 80'(exp_q.size()), 80'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
